// File: rtl/stream_sink.sv
// -----------------------------------------------------------------------------
// stream_sink
//   Capture block for the tail of a valid-qualified sample stream. Each valid
//   input sample is written into a small show-ahead register FIFO. A downstream
//   reader drains the FIFO through a valid/ready handshake. Samples that arrive
//   while the FIFO is full, with no pop in the same cycle, are dropped and raise
//   a sticky overflow flag. Optional signed min/max statistics are kept for
//   every accepted sample.
//
// Parameters
//   DATA_W    sample width (signed two's complement)
//   DEPTH     FIFO entries, power of two, >= 2
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   in_valid     in   sample present on in_data (no backpressure)
//   in_data      in   signed sample
//   clear        in   synchronous flush of FIFO, flags and stats (top priority)
//   out_ready    in   reader takes the head sample this cycle
//   out_valid    out  FIFO non-empty
//   out_data     out  head sample (show-ahead)
//   count        out  occupancy 0..DEPTH
//   overflow     out  sticky drop flag
//   min_val      out  signed minimum of accepted samples
//   max_val      out  signed maximum of accepted samples
//   stats_valid  out  at least one sample accepted since reset/clear
//
// Build option
//   STREAM_SINK_STATS_EN  when defined, min/max tracking is compiled in;
//                         otherwise min_val, max_val and stats_valid are 0.
// -----------------------------------------------------------------------------
module stream_sink #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       clear,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [DATA_W-1:0]          min_val,
    output logic [DATA_W-1:0]          max_val,
    output logic                       stats_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ZERO_PTR = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_PTR  = {{(AW-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              overflow_r;

    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;

    // Handshake decode: a pop frees a slot, so a push at full still succeeds.
    always_comb begin
        full_s = 1'b0;
        pop_s  = 1'b0;
        push_s = 1'b0;
        drop_s = 1'b0;
        full_s = (count_r == FULL_CNT);
        pop_s  = (count_r != ZERO_CNT) && out_ready;
        if (in_valid) begin
            push_s = !full_s || pop_s;
            drop_s = full_s && !pop_s;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Sample storage; cleared only by reset, a flush leaves stale data behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s && !clear) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointers, occupancy and sticky overflow; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= ZERO_PTR;
            rd_ptr_r   <= ZERO_PTR;
            count_r    <= ZERO_CNT;
            overflow_r <= 1'b0;
        end else if (clear) begin
            wr_ptr_r   <= ZERO_PTR;
            rd_ptr_r   <= ZERO_PTR;
            count_r    <= ZERO_CNT;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_CNT;
                2'b01:   count_r <= count_r - ONE_CNT;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign out_valid = (count_r != ZERO_CNT);
    assign out_data  = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign overflow  = overflow_r;

`ifdef STREAM_SINK_STATS_EN
    logic [DATA_W-1:0] min_r;
    logic [DATA_W-1:0] max_r;
    logic              stats_valid_r;

    // Signed extremes of accepted samples; the first one loads both bounds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_r         <= {DATA_W{1'b0}};
            max_r         <= {DATA_W{1'b0}};
            stats_valid_r <= 1'b0;
        end else if (clear) begin
            min_r         <= {DATA_W{1'b0}};
            max_r         <= {DATA_W{1'b0}};
            stats_valid_r <= 1'b0;
        end else if (push_s) begin
            stats_valid_r <= 1'b1;
            if (!stats_valid_r) begin
                min_r <= in_data;
                max_r <= in_data;
            end else begin
                if ($signed(in_data) < $signed(min_r)) begin
                    min_r <= in_data;
                end
                if ($signed(in_data) > $signed(max_r)) begin
                    max_r <= in_data;
                end
            end
        end
    end

    assign min_val     = min_r;
    assign max_val     = max_r;
    assign stats_valid = stats_valid_r;
`else
    assign min_val     = {DATA_W{1'b0}};
    assign max_val     = {DATA_W{1'b0}};
    assign stats_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stream_sink.sv
// -----------------------------------------------------------------------------
// tb_stream_sink
//   Self-checking bench for stream_sink. A queue-based reference model tracks
//   FIFO contents, the drop flag and the signed statistics; directed sequences
//   plus randomized traffic are compared against the DUT after every edge.
// -----------------------------------------------------------------------------
module tb_stream_sink;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          clear;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;
    logic          overflow;
    logic [DW-1:0] min_val;
    logic [DW-1:0] max_val;
    logic          stats_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [DW-1:0] q[$];
    logic          m_ovf;
    logic [DW-1:0] m_min;
    logic [DW-1:0] m_max;
    logic          m_sv;

    stream_sink #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .clear       (clear),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .count       (count),
        .overflow    (overflow),
        .min_val     (min_val),
        .max_val     (max_val),
        .stats_valid (stats_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_min = '0;
        m_max = '0;
        m_sv  = 1'b0;
    endtask

    // Apply one cycle of FIFO rules to the model from the current inputs.
    task automatic model_step();
        bit popped;
        if (clear) begin
            model_reset();
        end else begin
            popped = (q.size() != 0) && out_ready;
            if (popped) void'(q.pop_front());
            if (in_valid) begin
                if (q.size() < DEPTH) begin
                    q.push_back(in_data);
                    if (!m_sv) begin
                        m_min = in_data;
                        m_max = in_data;
                        m_sv  = 1'b1;
                    end else begin
                        if ($signed(in_data) < $signed(m_min)) m_min = in_data;
                        if ($signed(in_data) > $signed(m_max)) m_max = in_data;
                    end
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        check_eq("count", {{(32-CW){1'b0}}, count}, q.size());
        check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (q.size() != 0) check_eq("out_data", {16'd0, out_data}, {16'd0, q[0]});
`ifdef STREAM_SINK_STATS_EN
        check_eq("min_val", {16'd0, min_val}, {16'd0, m_min});
        check_eq("max_val", {16'd0, max_val}, {16'd0, m_max});
        check_eq("stats_valid", {31'd0, stats_valid}, {31'd0, m_sv});
`else
        check_eq("min_val_off", {16'd0, min_val}, 32'd0);
        check_eq("max_val_off", {16'd0, max_val}, 32'd0);
        check_eq("stats_valid_off", {31'd0, stats_valid}, 32'd0);
`endif
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        clear     = clr;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
        check_eq({tag, "_count"}, {{(32-CW){1'b0}}, count}, 32'd0);
        check_eq({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        check_eq({tag, "_min"}, {16'd0, min_val}, 32'd0);
        check_eq({tag, "_max"}, {16'd0, max_val}, 32'd0);
        check_eq({tag, "_sv"}, {31'd0, stats_valid}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] v;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        #20;
        @(negedge clk);
        rst = 1'b0;

        // stream -3..3 with a gap, reader stalled
        for (int i = -3; i <= 3; i++) begin
            v = DW'(i);
            if (i == 0) step(1'b0, '0, 1'b0, 1'b0);
            step(1'b1, v, 1'b0, 1'b0);
        end
        check_eq("stream_count7", {{(32-CW){1'b0}}, count}, 32'd7);
`ifdef STREAM_SINK_STATS_EN
        check_eq("stream_min", {16'd0, min_val}, 32'h0000_fffd);
        check_eq("stream_max", {16'd0, max_val}, 32'd3);
`endif
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_eq("stream_drained", {31'd0, out_valid}, 32'd0);

        // fill 10..17, drop 18
        for (int i = 10; i <= 17; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b1, 16'd18, 1'b0, 1'b0);
        check_eq("drop_ovf", {31'd0, overflow}, 32'd1);
        check_eq("drop_count", {{(32-CW){1'b0}}, count}, 32'd8);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

        // full with simultaneous push 99 and pop
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 10; i <= 17; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b1, 16'd99, 1'b1, 1'b0);
        check_eq("fullpp_count", {{(32-CW){1'b0}}, count}, 32'd8);
        check_eq("fullpp_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_eq("fullpp_last", {16'd0, out_data}, 32'd99);
        step(1'b0, '0, 1'b1, 1'b0);

        // 20 push/pop pairs across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(i), 1'b1, 1'b0);
            check_eq("wrap_head", {16'd0, out_data}, i);
        end
        step(1'b0, '0, 1'b1, 1'b0);

        // clear at count 4 with overflow set and a same-cycle sample
        for (int i = 0; i < 9; i++) step(1'b1, DW'(30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_eq("preclr_count", {{(32-CW){1'b0}}, count}, 32'd4);
        check_eq("preclr_ovf", {31'd0, overflow}, 32'd1);
        step(1'b1, 16'd5, 1'b0, 1'b1);
        check_eq("clr_count", {{(32-CW){1'b0}}, count}, 32'd0);
        check_eq("clr_ovf", {31'd0, overflow}, 32'd0);
        check_eq("clr_valid", {31'd0, out_valid}, 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 60) == 0));
        end

        // asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, DW'(-100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
